spwm_seq_ctrl: RTL and testbench
================================

# spwm_seq_ctrl

Sequencer for the sine-PWM modulator. Runs a period counter that shadows the PWM top value, steps a phase accumulator once per PWM period, fetches a sine sample from an external synchronous ROM, scales it by a soft-ramped amplitude, and commits the resulting duty value glitch-free at each period boundary. It sits between the sine table and the PWM comparator, driving the comparator's 13-bit duty input and owning start, stop and soft-start/soft-stop sequencing.

## Interface
- PERIOD_TOP, 5000, PWM top value; the period is PERIOD_TOP+1 clocks; must be ≥ 8.
- DUTY_W, 13, duty and table-data width.
- PHASE_W, 16, phase accumulator width.
- ADDR_W, 6, table address width; address = phase[PHASE_W-1 -: ADDR_W].
- RAMP_STEP, 64, amplitude change per period during ramps (1..256).
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse request to run.
- stop  in  1  request to ramp down and stop; wins over start.
- freq_word  in  PHASE_W  phase increment per period; sampled at wrap.
- amp  in  9  target amplitude, 0..256 (256 = full scale); values >256 are treated as 256.
- tbl_addr  out  ADDR_W  ROM address, registered.
- tbl_data  in  DUTY_W  ROM data, valid one cycle after tbl_addr; range 0..PERIOD_TOP, centred on CENTER = PERIOD_TOP/2.
- duty  out  DUTY_W  duty value to the PWM comparator.
- period_start  out  1  high during cycles where cnt==0 and state≠IDLE.
- busy  out  1  state≠IDLE.
- active  out  1  state==RUN.

## Operation
- States: IDLE, RAMP_UP, RUN, RAMP_DOWN.
- IDLE: cnt held 0, phase 0, amp_eff 0, duty 0 (PWM held low). start=1 and stop=0 → RAMP_UP next cycle; cnt begins counting from 0. stop in IDLE is ignored.
- Non-IDLE: cnt counts 0..PERIOD_TOP and wraps to 0. A "wrap" is the edge leaving cnt==PERIOD_TOP.
- Actions at each wrap, evaluated together:
  - duty ← shadow;
  - phase ← phase + freq_word (mod 2^PHASE_W);
  - amp_eff step;
  - state transition.
- RAMP_UP at wrap: stop → RAMP_DOWN. Otherwise amp_eff ← min(amp_eff+RAMP_STEP, amp). If the result equals amp → RUN.
- RUN at wrap: stop → RAMP_DOWN. Otherwise amp_eff moves toward amp by at most RAMP_STEP.
- RAMP_DOWN at wrap:
  - amp_eff==0 → IDLE, with duty ← 0 and phase ← 0;
  - else start=1 and stop=0 → RAMP_UP (amp_eff keeps its value and is not stepped at this wrap);
  - else amp_eff ← max(amp_eff−RAMP_STEP, 0).
- Duty arithmetic:
  - d = tbl_data − CENTER, signed, DUTY_W+1 bits;
  - p = d × amp_eff, signed, full width;
  - s = CENTER + (p >>> 8), arithmetic shift;
  - shadow ← clamp(s, 0, PERIOD_TOP).
- Simultaneous start and stop: stop wins.
- amp, freq_word and start/stop changes mid-period take effect only at the next wrap. Exception: start in IDLE takes effect on the next cycle.

## Timing
- Reset (async assert): state IDLE, cnt 0, phase 0, amp_eff 0, shadow CENTER, duty 0, tbl_addr 0, period_start 0, busy 0, active 0. Outputs change immediately on rst_n fall, without waiting for clk.
- Fetch pipeline in each period, as register values at the named cnt:
  - tbl_addr updates at the edge leaving cnt==1, from the post-wrap phase;
  - tbl_data is sampled at the edge leaving cnt==2;
  - the product is registered at the edge leaving cnt==3;
  - shadow is registered at the edge leaving cnt==4.
- Latency: the sample for period k is committed to duty at the start of period k+1. duty changes only at wraps.
- First period after start: duty=0. From the first wrap on, duty reflects amp_eff=0, i.e. CENTER.
- period_start is high exactly one cycle per period.

## Test plan
- Reset: assert rst_n=0 mid-RUN → duty=0, busy=0, period_start=0 with no clk edge; after release, remain IDLE until start.
- Soft start: amp=256, RAMP_STEP=64, start pulse → amp_eff 64,128,192,256 at wraps 1–4; active=1 after wrap 4; period_start every 5001 cycles.
- Scaling: tbl_data=5000, amp_eff=128 → duty=3750 at the following wrap; tbl_data=2500 → duty=2500.
- Clamp: tbl_data=8191, amp_eff=256 → duty=5000; tbl_data=0, amp_eff=256 → duty=0.
- Phase and address: freq_word=0x0400 → tbl_addr 1,2,3,… per period, wrapping 63→0. freq_word changed mid-period → the new step is used only from the next wrap.
- Stop: start and stop both high in RUN → RAMP_DOWN; amp_eff decreases 192,128,64,0; the next wrap after that → IDLE with duty=0. start during RAMP_DOWN → RAMP_UP from the current amp_eff.

Source files
------------

// File: rtl/spwm_seq_ctrl_if.sv
// Request, sine-table and comparator-side signals of the sine-PWM sequencer.
// The sequencer takes the master view; the host/ROM/comparator side takes the slave view.
interface spwm_seq_ctrl_if #(
  parameter int DUTY_W  = 13,
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 6
);
  logic               start;
  logic               stop;
  logic [PHASE_W-1:0] freq_word;
  logic [8:0]         amp;
  logic [ADDR_W-1:0]  tbl_addr;
  logic [DUTY_W-1:0]  tbl_data;
  logic [DUTY_W-1:0]  duty;
  logic               period_start;
  logic               busy;
  logic               active;

  modport master (
    input  start, stop, freq_word, amp, tbl_data,
    output tbl_addr, duty, period_start, busy, active
  );

  modport slave (
    output start, stop, freq_word, amp, tbl_data,
    input  tbl_addr, duty, period_start, busy, active
  );
endinterface

// File: rtl/spwm_seq_ctrl.sv
// Sine-PWM sequencer: period counter, per-period phase step, sine fetch, soft-ramped
// amplitude scaling; the sample fetched in period k is committed to duty at the wrap into k+1.
module spwm_seq_ctrl #(
  parameter int PERIOD_TOP = 5000,
  parameter int DUTY_W     = 13,
  parameter int PHASE_W    = 16,
  parameter int ADDR_W     = 6,
  parameter int RAMP_STEP  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  spwm_seq_ctrl_if.master bus
);
  localparam int CNT_W  = $clog2(PERIOD_TOP + 1);
  localparam int CENTER = PERIOD_TOP / 2;
  localparam int D_W    = DUTY_W + 1;
  localparam int P_W    = D_W + 10;

  localparam logic [CNT_W-1:0]        CNT_TOP  = CNT_W'(PERIOD_TOP);
  localparam logic signed [D_W-1:0]   CENTER_D = D_W'(CENTER);
  localparam logic signed [P_W-1:0]   CENTER_P = P_W'(CENTER);
  localparam logic signed [P_W-1:0]   TOP_P    = P_W'(PERIOD_TOP);
  localparam logic [8:0]              AMP_FULL = 9'd256;
  localparam logic [9:0]              STEP_X   = 10'(RAMP_STEP);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [8:0]              amp_eff_q, amp_eff_d;
  logic [DUTY_W-1:0]       data_q, data_d;
  logic signed [P_W-1:0]   prod_q, prod_d;
  logic [DUTY_W-1:0]       shadow_q, shadow_d;
  logic [DUTY_W-1:0]       duty_q, duty_d;
  logic [ADDR_W-1:0]       tbl_addr_q, tbl_addr_d;
  logic                    period_start_q, period_start_d;
  logic                    busy_q, busy_d;
  logic                    active_q, active_d;

  logic                    wrap;
  logic [8:0]              amp_tgt, amp_up, amp_dn, amp_run;
  logic [9:0]              up_sum, dn_lim;
  logic signed [D_W-1:0]   diff;
  logic signed [P_W-1:0]   prod_calc, scaled;
  logic [DUTY_W-1:0]       shadow_calc;

  assign wrap = (state_q != IDLE) && (cnt_q == CNT_TOP);

  // Amplitude candidates; all comparisons done in 10 bits so amp_eff+step cannot overflow.
  assign amp_tgt = (bus.amp > AMP_FULL) ? AMP_FULL : bus.amp;
  assign up_sum  = {1'b0, amp_eff_q} + STEP_X;
  assign amp_up  = (up_sum >= {1'b0, amp_tgt}) ? amp_tgt : up_sum[8:0];
  assign amp_dn  = ({1'b0, amp_eff_q} > STEP_X) ? (amp_eff_q - STEP_X[8:0]) : 9'd0;
  assign dn_lim  = {1'b0, amp_tgt} + STEP_X;
  assign amp_run = (amp_eff_q < amp_tgt) ? amp_up :
                   (({1'b0, amp_eff_q} > dn_lim) ? (amp_eff_q - STEP_X[8:0]) : amp_tgt);

  // Scale the centred sample; >>> keeps negative half-waves flooring correctly.
  assign diff        = $signed({1'b0, data_q}) - CENTER_D;
  assign prod_calc   = diff * $signed({1'b0, amp_eff_q});
  assign scaled      = CENTER_P + (prod_q >>> 8);
  assign shadow_calc = scaled[P_W-1]    ? {DUTY_W{1'b0}} :
                       (scaled > TOP_P) ? DUTY_W'(PERIOD_TOP) : scaled[DUTY_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    amp_eff_d  = amp_eff_q;
    data_d     = data_q;
    prod_d     = prod_q;
    shadow_d   = shadow_q;
    duty_d     = duty_q;
    tbl_addr_d = tbl_addr_q;

    if (state_q == IDLE) begin
      cnt_d     = '0;
      phase_d   = '0;
      amp_eff_d = '0;
      duty_d    = '0;
      if (bus.start && !bus.stop) state_d = RAMP_UP;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(1)) tbl_addr_d = phase_q[PHASE_W-1 -: ADDR_W];
      if (cnt_q == CNT_W'(2)) data_d     = bus.tbl_data;
      if (cnt_q == CNT_W'(3)) prod_d     = prod_calc;
      if (cnt_q == CNT_W'(4)) shadow_d   = shadow_calc;

      if (wrap) begin
        duty_d  = shadow_q;
        phase_d = phase_q + bus.freq_word;
        case (state_q)
          RAMP_UP: begin
            if (bus.stop) begin
              state_d = RAMP_DOWN;
            end else begin
              amp_eff_d = amp_up;
              if (amp_up == amp_tgt) state_d = RUN;
            end
          end
          RUN: begin
            if (bus.stop) state_d = RAMP_DOWN;
            else          amp_eff_d = amp_run;
          end
          RAMP_DOWN: begin
            if (amp_eff_q == 9'd0) begin
              state_d = IDLE;
              duty_d  = '0;
              phase_d = '0;
            end else if (bus.start && !bus.stop) begin
              state_d = RAMP_UP;
            end else begin
              amp_eff_d = amp_dn;
            end
          end
          default: ;
        endcase
      end
    end

    period_start_d = (state_d != IDLE) && (cnt_d == '0);
    busy_d         = (state_d != IDLE);
    active_d       = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      phase_q        <= '0;
      amp_eff_q      <= '0;
      data_q         <= '0;
      prod_q         <= '0;
      shadow_q       <= DUTY_W'(CENTER);
      duty_q         <= '0;
      tbl_addr_q     <= '0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
      active_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      amp_eff_q      <= amp_eff_d;
      data_q         <= data_d;
      prod_q         <= prod_d;
      shadow_q       <= shadow_d;
      duty_q         <= duty_d;
      tbl_addr_q     <= tbl_addr_d;
      period_start_q <= period_start_d;
      busy_q         <= busy_d;
      active_q       <= active_d;
    end
  end

  assign bus.tbl_addr     = tbl_addr_q;
  assign bus.duty         = duty_q;
  assign bus.period_start = period_start_q;
  assign bus.busy         = busy_q;
  assign bus.active       = active_q;
endmodule

// File: tb/tb_spwm_seq_ctrl.sv
// Bench for spwm_seq_ctrl: directed sequencing steps plus randomized amp/freq/start/stop,
// checked every cycle against a period-level reference model.
module tb_spwm_seq_ctrl;
  localparam int PT     = 100;
  localparam int CENTER = PT / 2;
  localparam int STEP   = 64;
  localparam int S_IDLE = 0, S_UP = 1, S_RUN = 2, S_DN = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spwm_seq_ctrl_if #(.DUTY_W(13), .PHASE_W(16), .ADDR_W(6)) bus ();

  spwm_seq_ctrl #(
    .PERIOD_TOP(PT), .DUTY_W(13), .PHASE_W(16), .ADDR_W(6), .RAMP_STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [12:0] rom [64];
  assign bus.tbl_data = rom[bus.tbl_addr];

  int checks   = 0;
  int failures = 0;
  int m_state, m_cnt, m_phase, m_amp, m_duty, m_shadow, m_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_state = S_IDLE; m_cnt = 0; m_phase = 0; m_amp = 0;
    m_duty = 0; m_shadow = CENTER; m_addr = 0;
  endtask

  // Reference: one call per rising edge, using the inputs held since the previous negedge.
  task automatic m_edge();
    int tgt, d, s;
    if (!rst_n) begin m_reset(); return; end
    tgt = (int'(bus.amp) > 256) ? 256 : int'(bus.amp);
    if (m_state == S_IDLE) begin
      if (bus.start && !bus.stop) m_state = S_UP;
    end else if (m_cnt == PT) begin
      m_cnt   = 0;
      m_duty  = m_shadow;
      m_phase = (m_phase + int'(bus.freq_word)) % 65536;
      case (m_state)
        S_UP: begin
          if (bus.stop) m_state = S_DN;
          else begin
            m_amp = (m_amp + STEP < tgt) ? m_amp + STEP : tgt;
            if (m_amp == tgt) m_state = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.stop) m_state = S_DN;
          else if (m_amp < tgt) m_amp = (m_amp + STEP < tgt) ? m_amp + STEP : tgt;
          else m_amp = (m_amp - STEP > tgt) ? m_amp - STEP : tgt;
        end
        default: begin
          if (m_amp == 0) begin m_state = S_IDLE; m_duty = 0; m_phase = 0; end
          else if (bus.start && !bus.stop) m_state = S_UP;
          else m_amp = (m_amp > STEP) ? m_amp - STEP : 0;
        end
      endcase
    end else begin
      m_cnt++;
      if (m_cnt == 2) m_addr = m_phase >> 10;
      if (m_cnt == 3) begin
        d = int'(rom[m_addr]) - CENTER;
        s = CENTER + ((d * m_amp) >>> 8);
        m_shadow = (s < 0) ? 0 : ((s > PT) ? PT : s);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    chk("duty",         32'(bus.duty),         32'(m_duty));
    chk("tbl_addr",     32'(bus.tbl_addr),     32'(m_addr));
    chk("busy",         32'(bus.busy),         32'(m_state != S_IDLE));
    chk("active",       32'(bus.active),       32'(m_state == S_RUN));
    chk("period_start", 32'(bus.period_start), 32'(m_state != S_IDLE && m_cnt == 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Advance until k period_start pulses; leaves the bench at cnt==0 of a period.
  task automatic wait_periods(input int k);
    int seen   = 0;
    int budget = k * (PT + 1) + 4;
    while (seen < k && budget > 0) begin
      cyc();
      budget--;
      if (bus.period_start === 1'b1) seen++;
    end
    chk("period_wait", 32'(seen), 32'(k));
  endtask

  task automatic wait_active();
    int budget = 12 * (PT + 1);
    while (bus.active !== 1'b1 && budget > 0) begin cyc(); budget--; end
    chk("reach_run", 32'(bus.active), 32'd1);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.freq_word = '0; bus.amp = '0;
    for (int i = 0; i < 64; i++) rom[i] = 13'($urandom_range(0, 8191));
    rom[0] = 13'(PT);
    m_reset();

    // Asynchronous reset at start-up, checked between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_duty", 32'(bus.duty), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ps",   32'(bus.period_start), 32'd0);
    chk("rst_addr", 32'(bus.tbl_addr), 32'd0);
    run(3);
    rst_n = 1'b1;

    // stop alone in IDLE is ignored
    bus.stop = 1'b1;
    run(5);
    bus.stop = 1'b0;

    // Soft start: duty 50,62,75,87 at wraps 1-4, then full scale 100.
    bus.amp = 9'd256;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    wait_periods(4);
    chk("soft_active", 32'(bus.active), 32'd1);
    chk("soft_duty4",  32'(bus.duty), 32'd87);
    wait_periods(1);
    chk("soft_duty5",  32'(bus.duty), 32'd100);

    // Scaling at amp 128: top sample -> 75, centre sample -> centre.
    bus.amp = 9'd128;
    wait_periods(3);
    chk("scale_top", 32'(bus.duty), 32'd75);
    rom[0] = 13'(CENTER);
    wait_periods(1);
    chk("scale_ctr", 32'(bus.duty), 32'(CENTER));

    // Clamp at full amplitude.
    bus.amp = 9'd256;
    rom[0] = 13'd8191;
    wait_periods(2);
    chk("clamp_hi", 32'(bus.duty), 32'(PT));
    rom[0] = 13'd0;
    wait_periods(1);
    chk("clamp_lo", 32'(bus.duty), 32'd0);

    // Phase stepping across the 63->0 address wrap, then a mid-period step change.
    rom[0] = 13'($urandom_range(0, PT));
    bus.freq_word = 16'h0400;
    wait_periods(66);
    run(37);
    bus.freq_word = 16'h0800;
    wait_periods(3);

    // Randomized amplitude, frequency and start/stop traffic.
    for (int p = 0; p < 40; p++) begin
      run($urandom_range(5, 90));
      bus.amp       = 9'($urandom_range(0, 511));
      bus.freq_word = 16'($urandom);
      bus.start     = ($urandom_range(0, 2) == 0);
      bus.stop      = ($urandom_range(0, 7) == 0);
      run(PT + 1);
    end

    // Stop with start also high in RUN, then restart from mid ramp-down.
    bus.amp = 9'd256; bus.stop = 1'b0; bus.start = 1'b1;
    wait_active();
    wait_periods(1);
    run(20);
    bus.stop = 1'b1;
    wait_periods(1);
    chk("stop_active", 32'(bus.active), 32'd0);
    chk("stop_busy",   32'(bus.busy), 32'd1);
    wait_periods(1);
    run(10);
    bus.stop = 1'b0;
    wait_periods(2);
    bus.start = 1'b0;
    wait_active();

    // Full ramp-down to IDLE.
    bus.stop = 1'b1;
    run(7 * (PT + 1));
    chk("down_busy", 32'(bus.busy), 32'd0);
    chk("down_duty", 32'(bus.duty), 32'd0);
    bus.stop = 1'b0;

    // Asynchronous reset mid-RUN, no clock edge in between.
    bus.start = 1'b1;
    wait_active();
    bus.start = 1'b0;
    run(30);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_duty", 32'(bus.duty), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ps",   32'(bus.period_start), 32'd0);
    chk("arst_act",  32'(bus.active), 32'd0);
    m_reset();
    run(3);
    rst_n = 1'b1;
    run(2 * (PT + 1));
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
